// File: rtl/xnor2_cell_pkg.sv
// Shared constants and helpers for the bitwise XNOR cell.
// Keeps the legal width range and the reference bit function in one place.
package xnor2_cell_pkg;

    localparam int unsigned XNOR2_WIDTH_MIN = 1;
    localparam int unsigned XNOR2_WIDTH_MAX = 1024;

    // Reference per-bit function; X/Z on either operand propagates to the result.
    function automatic logic xnor2_fn(input logic a, input logic b);
        return ~(a ^ b);
    endfunction

    function automatic bit xnor2_width_ok(input int w);
        return (w >= int'(XNOR2_WIDTH_MIN)) && (w <= int'(XNOR2_WIDTH_MAX));
    endfunction

endpackage

// File: rtl/xnor2_bit.sv
// Single-bit combinational XNOR leaf, replicated by xnor2_cell.
module xnor2_bit
    import xnor2_cell_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    output logic c_o
);

    assign c_o = xnor2_fn(a_i, b_i);

endmodule

// File: rtl/xnor2_cell.sv
// Bitwise 2-input XNOR with a zero-latency output and a flopped copy plus valid.
// The combinational path ignores clock and reset so it stays usable during reset.
module xnor2_cell
    import xnor2_cell_pkg::*;
#(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    input  logic               v_i,
    output logic [width_p-1:0] c_o,
    output logic [width_p-1:0] c_r_o,
    output logic               v_r_o
);

    if (!xnor2_width_ok(width_p)) begin : g_bad_width
        $error("xnor2_cell: width_p=%0d outside legal range 1..1024", width_p);
    end

    logic [width_p-1:0] c_comb;
    logic [width_p-1:0] c_r_reg;
    logic [width_p-1:0] c_r_next;
    logic               v_r_reg;
    logic               v_r_next;

    for (genvar gi = 0; gi < width_p; gi++) begin : g_bit
        xnor2_bit u_bit (
            .a_i (a_i[gi]),
            .b_i (b_i[gi]),
            .c_o (c_comb[gi])
        );
    end

    // Data holds when not qualified; valid is a one-cycle pulse per accepted input.
    always_comb begin
        c_r_next = c_r_reg;
        v_r_next = v_i;
        if (v_i) begin
            c_r_next = c_comb;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            c_r_reg <= '0;
            v_r_reg <= 1'b0;
        end else begin
            c_r_reg <= c_r_next;
            v_r_reg <= v_r_next;
        end
    end

    assign c_o   = c_comb;
    assign c_r_o = c_r_reg;
    assign v_r_o = v_r_reg;

endmodule

// File: tb/tb_xnor2_cell.sv
// Directed bench for xnor2_cell at width 1 and width 8 sharing one clock and reset.
module tb_xnor2_cell;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
    logic       c1, cr1, vr1;
    logic [7:0] a8 = '0, b8 = '0;
    logic       v8 = 1'b0;
    logic [7:0] c8, cr8;
    logic       vr8;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    xnor2_cell #(.width_p(1)) dut1 (
        .clk_i(clk), .reset_i(rst), .a_i(a1), .b_i(b1), .v_i(v1),
        .c_o(c1), .c_r_o(cr1), .v_r_o(vr1)
    );

    xnor2_cell #(.width_p(8)) dut8 (
        .clk_i(clk), .reset_i(rst), .a_i(a8), .b_i(b8), .v_i(v8),
        .c_o(c8), .c_r_o(cr8), .v_r_o(vr8)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %-22s observed=%h expected=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] ab;
        logic [3:0] tt;
        tt = 4'b1001; // index {a,b}: 00->1, 01->0, 10->0, 11->1

        // Reset held: combinational path follows the truth table, registers stay clear
        // even with v_i high across clock edges.
        v1 = 1'b1;
        v8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            @(negedge clk);
            a1 = ab[1];
            b1 = ab[0];
            #10;
            check($sformatf("rst_c_o_%b", ab), {7'b0, c1}, {7'b0, tt[i]});
            check($sformatf("rst_c_r_o_%b", ab), {7'b0, cr1}, 8'h00);
            check($sformatf("rst_v_r_o_%b", ab), {7'b0, vr1}, 8'h00);
        end
        check("rst_w8_c_r_o", cr8, 8'h00);

        @(negedge clk);
        v1 = 1'b0;
        v8 = 1'b0;
        rst = 1'b0;

        // Truth table sweep out of reset, sampled 10 ns after each apply.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            @(negedge clk);
            a1 = ab[1];
            b1 = ab[0];
            #10;
            check($sformatf("sweep_c_o_%b", ab), {7'b0, c1}, {7'b0, tt[i]});
        end

        // Registered path: capture then hold with v_i low (operands changed so hold matters).
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        @(posedge clk); #1;
        check("reg_capture_c_r_o", {7'b0, cr1}, 8'h01);
        check("reg_capture_v_r_o", {7'b0, vr1}, 8'h01);
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; v1 = 1'b0;
        @(posedge clk); #1;
        check("reg_hold_c_r_o", {7'b0, cr1}, 8'h01);
        check("reg_hold_v_r_o", {7'b0, vr1}, 8'h00);

        // Width 8 combinational vectors.
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h0F;
        #1;
        check("w8_c_o_a5_0f", c8, 8'h55);
        a8 = 8'h3C; b8 = 8'h3C;
        #1;
        check("w8_c_o_3c_3c", c8, 8'hFF);
        a8 = 8'hF0; b8 = 8'hCC;
        #1;
        check("w8_c_o_f0_cc", c8, 8'hC3);

        // Back-to-back captures: one result per cycle, one cycle latency.
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h0F; v8 = 1'b1;
        @(posedge clk); #1;
        check("w8_b2b_first", cr8, 8'h55);
        check("w8_b2b_first_v", {7'b0, vr8}, 8'h01);
        @(negedge clk);
        a8 = 8'h00; b8 = 8'hFF;
        @(posedge clk); #1;
        check("w8_b2b_second", cr8, 8'h00);
        check("w8_b2b_second_v", {7'b0, vr8}, 8'h01);
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34;
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b0;

        // Async reset mid-cycle: outputs clear without a clock edge.
        @(posedge clk); #1;
        check("pre_async_w8_c_r_o", cr8, 8'hD9);
        check("pre_async_v_r_o", {7'b0, vr1}, 8'h01);
        #1;
        rst = 1'b1;
        #1;
        check("async_w1_c_r_o", {7'b0, cr1}, 8'h00);
        check("async_w1_v_r_o", {7'b0, vr1}, 8'h00);
        check("async_w8_c_r_o", cr8, 8'h00);
        check("async_w8_v_r_o", {7'b0, vr8}, 8'h00);
        check("async_w8_c_o_live", c8, 8'hD9);

        // First capture after deassertion lands on the first edge with v_i high.
        @(negedge clk);
        rst = 1'b0;
        a8 = 8'h0F; b8 = 8'h0F;
        @(posedge clk); #1;
        check("post_rst_capture", cr8, 8'hFF);
        check("post_rst_capture_v", {7'b0, vr8}, 8'h01);
        @(negedge clk);
        v8 = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle_v", {7'b0, vr8}, 8'h00);
        check("post_rst_idle_hold", cr8, 8'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
